// File: rtl/serial_sub_sequencer.sv
// serial_sub_sequencer
// Bit-serial driver for an external 1-bit full-subtractor stage. Latches two
// WIDTH-bit operands plus an initial borrow, walks the stage LSB first, and
// returns the assembled difference and final borrow with a one-cycle valid.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; ready high, stage inputs held at 0
// S_SHIFT | one bit pair per clock through the stage, idx = bit index
module serial_sub_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             ready_o,
  output logic             stg_a_o,
  output logic             stg_b_o,
  output logic             stg_bin_o,
  input  logic             stg_d_i,
  input  logic             stg_bout_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o,
  output logic             valid_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] IDX_ONE  = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] idx_q,   idx_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             brw_q,   brw_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0] diff_q,  diff_d;
  logic             bout_q,  bout_d;
  logic             valid_q, valid_d;

  // Next-state logic: accept in IDLE, collect one stage result per SHIFT cycle.
  // diff is loaded from acc_d so the final bit lands in the same edge and the
  // output never shows a partially built word.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          brw_d   = bin_i;
          idx_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d[idx_q] = stg_d_i;
        brw_d        = stg_bout_i;
        idx_d        = idx_q + IDX_ONE;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          diff_d  = acc_d;
          bout_d  = stg_bout_i;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset mid-operation discards it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      acc_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      valid_q <= valid_d;
    end
  end

  // Stage drive is forced to 0 outside SHIFT so the stage sees a quiet input.
  always_comb begin
    stg_a_o   = 1'b0;
    stg_b_o   = 1'b0;
    stg_bin_o = 1'b0;
    if (state_q == S_SHIFT) begin
      stg_a_o   = a_q[idx_q];
      stg_b_o   = b_q[idx_q];
      stg_bin_o = brw_q;
    end
  end

  assign ready_o = (state_q == S_IDLE);
  assign diff_o  = diff_q;
  assign bout_o  = bout_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_serial_sub_sequencer.sv
// Testbench for serial_sub_sequencer with a behavioural 1-bit subtractor stage.
module tb_serial_sub_sequencer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             bin_i = 1'b0;
  logic             ready_o, stg_a_o, stg_b_o, stg_bin_o, bout_o, valid_o;
  logic             stg_d_i, stg_bout_i;
  logic [WIDTH-1:0] diff_o;

  always #5 clk = ~clk;

  // Stage model.
  always_comb begin
    stg_d_i    = stg_a_o ^ stg_b_o ^ stg_bin_o;
    stg_bout_i = (~stg_a_o & stg_b_o) | (~(stg_a_o ^ stg_b_o) & stg_bin_o);
  end

  serial_sub_sequencer #(.WIDTH(WIDTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .a_i(a_i), .b_i(b_i),
    .bin_i(bin_i), .ready_o(ready_o), .stg_a_o(stg_a_o), .stg_b_o(stg_b_o),
    .stg_bin_o(stg_bin_o), .stg_d_i(stg_d_i), .stg_bout_i(stg_bout_i),
    .diff_o(diff_o), .bout_o(bout_o), .valid_o(valid_o)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bo;
    int               cyc;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  int               cyc = 0;
  int               mbusy = 0;
  logic [WIDTH-1:0] ma = '0, mb = '0;
  logic             mbrw = 1'b0;
  logic             last_accept = 1'b0;
  logic [WIDTH-1:0] hold_d = '0;
  logic             hold_bo = 1'b0;
  logic             prev_valid = 1'b0;
  logic             mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model of acceptance/busy timing; pushes golden a-b-bin results.
  always @(posedge clk) begin
    int i;
    int full;
    exp_t e;
    cyc++;
    last_accept = 1'b0;
    if (rst_i) begin
      mbusy   = 0;
      mbrw    = 1'b0;
      ma      = '0;
      mb      = '0;
      hold_d  = '0;
      hold_bo = 1'b0;
      sb.delete();
    end else if (mbusy > 0) begin
      i     = WIDTH - mbusy;
      mbrw  = (~ma[i] & mb[i]) | (~(ma[i] ^ mb[i]) & mbrw);
      mbusy = mbusy - 1;
    end else if (start_i) begin
      ma    = a_i;
      mb    = b_i;
      mbrw  = bin_i;
      mbusy = WIDTH;
      full  = int'(a_i) - int'(b_i) - int'(bin_i);
      e.d   = WIDTH'(full);
      e.bo  = (full < 0);
      e.cyc = cyc + WIDTH;
      sb.push_back(e);
      last_accept = 1'b1;
    end
  end

  // Monitor: samples on the falling edge, pops the scoreboard on valid.
  always @(negedge clk) begin
    exp_t e;
    int   i;
    if (mon_en) begin
      check("ready", ready_o, (mbusy == 0));
      if (mbusy > 0) begin
        i = WIDTH - mbusy;
        check("stg_a", stg_a_o, ma[i]);
        check("stg_b", stg_b_o, mb[i]);
        check("stg_bin", stg_bin_o, mbrw);
      end else begin
        check("stg_idle", {stg_a_o, stg_b_o, stg_bin_o}, 0);
      end
      if (valid_o) begin
        check("valid_width", prev_valid, 0);
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("diff", diff_o, e.d);
          check("bout", bout_o, e.bo);
          check("latency", cyc, e.cyc);
          hold_d  = e.d;
          hold_bo = e.bo;
        end
      end else begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          e = sb.pop_front();
          check("missing_valid", cyc, e.cyc);
        end
      end
      check("diff_hold", diff_o, hold_d);
      check("bout_hold", bout_o, hold_bo);
      prev_valid = valid_o;
    end
  end

  // Present operands with start high until the model accepts; start stays high.
  task automatic issue(input int a, input int b, input int bin);
    int n;
    a_i     = WIDTH'(a);
    b_i     = WIDTH'(b);
    bin_i   = bin[0];
    start_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!last_accept && n < 20);
    if (!last_accept) check("accept_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    start_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_i  = 1'b0;
    mon_en = 1'b1;
    idle_cycles(2);

    // Directed vectors.
    issue(9, 3, 0);  idle_cycles(6);
    issue(3, 9, 0);  idle_cycles(6);
    issue(0, 0, 1);  idle_cycles(6);
    issue(15, 15, 0); idle_cycles(6);

    // Start held while busy with changing operands: second op waits for ready.
    issue(9, 3, 0);
    a_i = 4'd15; b_i = 4'd1; bin_i = 1'b1;
    @(posedge clk); #1;
    a_i = 4'd12; b_i = 4'd5; bin_i = 1'b0;
    issue(12, 5, 0);
    idle_cycles(7);

    // Reset on the second SHIFT edge aborts the operation.
    issue(9, 3, 0);
    start_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    idle_cycles(8);
    issue(9, 3, 0);  idle_cycles(6);

    // Exhaustive back-to-back sweep.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          issue(a, b, c);
    start_i = 1'b0;

    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    idle_cycles(2);
    if (sb.size() > 0) check("drain_timeout", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
